mbox_req_arb: RTL and testbench
===============================

// Module: mbox_req_arb
// PURPOSE
//  Arbitrates the single EBOX-side MBOX memory port among three requesters: EBOX (ebReq),
//  channel (chReq) and cache-clearer sweep (ccaReq). Latches the winner's request and holds
//  memReq until the MBOX accepts. Tracks the response, re-issues on retry, and times out to NXM.
//  Sits between ebox request logic and mbox; one transaction outstanding at a time.
// PARAMETERS
//  ADDR_W      23    request address width (maps to EBOX_VMA[13:35])
//  TIMEOUT_CYC 1024  cycles in WAIT without memResp before NXM error (>=2)
//  MAX_RETRY   3     retries allowed per transaction; the next retry is an error
//  RETRY_GAP   4     idle cycles between memRetry and re-issue (>=1)
//  STARVE_LIM  8     consecutive lost arbitrations before promotion (MBOX_ARB_STARVE_EN only)
// PORTS
//  clk        in   1       system clock; all state on rising edge
//  FPGA_RESET in   1       asynchronous, active-high reset
//  ebReq/chReq/ccaReq in 1 request; held high until matching *Done
//  ebWrite/chWrite  in 1   1=write, 0=read (CCA always read-sweep, write=0)
//  ebAdr/chAdr/ccaAdr in ADDR_W  request address, valid while *Req=1
//  memReq     out  1       request to MBOX; held until memStart
//  memWrite   out  1       latched write flag of owner
//  memAdr     out  ADDR_W  latched address of owner
//  memSrc     out  2       owner: 0=none 1=EB 2=CH 3=CCA
//  memStart   in   1       MBOX accepted memReq this cycle
//  memResp    in   1       MBOX completed the transaction (mboxRespIn)
//  memRetry   in   1       MBOX requests re-issue (cshEBOXRetry)
//  ebDone/chDone/ccaDone out 1  one-cycle completion pulse to owner
//  doneErr    out  1       qualifies *Done: transaction failed (timeout/retry limit)
//  nxmErr     out  1       one-cycle pulse, coincident with errored *Done
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, memSrc=0. Retry/timeout/starve counters=0.
//  Reset mid-transaction abandons it; no *Done is issued.
//  IDLE: if any req, pick winner: EB > CH > CCA (fixed). Latch adr/write/src. -> ISSUE next cycle.
//   Grant latency = 1 cycle (memReq rises the cycle after req is seen in IDLE).
//  ISSUE: memReq=1 with latched fields stable. On memStart -> WAIT; timeout counter cleared.
//   memStart & memResp same cycle: complete immediately (DONE path).
//  WAIT: memReq=0; timeout counter increments each cycle.
//   memResp -> *Done=1 (doneErr=0) for one cycle; -> IDLE.
//   memRetry (no memResp) -> RETRY if retryCnt<MAX_RETRY (retryCnt++); else ERROR.
//   memResp & memRetry same cycle: memResp wins.
//   Counter reaches TIMEOUT_CYC-1 with no memResp -> ERROR.
//  RETRY: count RETRY_GAP cycles -> ISSUE with the same latched request (no re-arbitration).
//  ERROR: one cycle; *Done=1, doneErr=1, nxmErr=1 -> IDLE.
//  Done handling: retryCnt cleared on every *Done. Next arbitration occurs the cycle after Done
//   (the IDLE cycle). The owner's req still high in the Done cycle is not a new request.
//  Requester dropping req after grant: ignored; the transaction runs to Done.
//  memStart/memResp/memRetry outside the expected states are ignored.
// CONFIGURATION
//  MBOX_ARB_STARVE_EN defined: per-requester lose counters for CH and CCA. Each counter
//   increments when that requester is asserted in IDLE but loses; it clears when that requester wins.
//   A counter ==STARVE_LIM promotes that requester above EB for the next arbitration.
//   If both are promoted, CH wins.
//  Undefined: strict EB>CH>CCA priority; no counters; STARVE_LIM unused.
// TESTING
//  1 Single EB read adr=0x00_1234, memStart at +2, memResp at +5 -> memReq 1 cycle after ebReq;
//    memSrc=1; ebDone one pulse, doneErr=0; busy low next cycle.
//  2 ebReq, chReq, ccaReq all asserted together, each responding -> service order EB,CH,CCA;
//    exactly one *Done each; never two memSrc owners overlap.
//  3 CH write, memRetry 3 times then memResp -> 3 re-issues, each RETRY_GAP=4 cycles after its
//    retry, same adr/write; chDone, doneErr=0. Repeat with 4 retries -> chDone+doneErr+nxmErr.
//  4 EB read, memStart, no memResp -> at TIMEOUT_CYC=1024 cycles after WAIT entry: ebDone,
//    doneErr=1, nxmErr=1 for 1 cycle; next ebReq serviced normally.
//  5 FPGA_RESET pulsed while in WAIT -> all outputs 0 at once, no *Done; state IDLE after release.
//  6 MBOX_ARB_STARVE_EN, ebReq continuous + ccaReq held -> CCA wins on arbitration 9 (after 8 losses);
//    without macro CCA never wins while ebReq high.

Source files
------------

// File: rtl/mbox_req_arb.sv
// Arbiter for the EBOX-side MBOX port: EB > CH > CCA, one transaction in flight, with retry and
// timeout-to-NXM handling. Define MBOX_ARB_STARVE_EN to promote starved CH/CCA requesters.
module mbox_req_arb #(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 4,
  parameter int unsigned STARVE_LIM  = 8
) (
  input  logic              clk,
  input  logic              FPGA_RESET,
  input  logic              ebReq,
  input  logic              chReq,
  input  logic              ccaReq,
  input  logic              ebWrite,
  input  logic              chWrite,
  input  logic [ADDR_W-1:0] ebAdr,
  input  logic [ADDR_W-1:0] chAdr,
  input  logic [ADDR_W-1:0] ccaAdr,
  output logic              memReq,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAdr,
  output logic [1:0]        memSrc,
  input  logic              memStart,
  input  logic              memResp,
  input  logic              memRetry,
  output logic              ebDone,
  output logic              chDone,
  output logic              ccaDone,
  output logic              doneErr,
  output logic              nxmErr,
  output logic              busy
);

  localparam int unsigned ToW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned RtW  = $clog2(MAX_RETRY + 1);
  localparam int unsigned GapW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcEb   = 2'd1;
  localparam logic [1:0] SrcCh   = 2'd2;
  localparam logic [1:0] SrcCca  = 2'd3;

  if (TIMEOUT_CYC < 2 || RETRY_GAP < 1 || STARVE_LIM < 1) begin : g_param_check
    $error("mbox_req_arb: illegal parameter value");
  end

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StRetry, StError} state_e;

  state_e            state_q, state_d;
  logic [1:0]        src_q, src_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              write_q, write_d;
  logic [RtW-1:0]    retry_q, retry_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [1:0]        win_src;
  logic              done, err;

`ifdef MBOX_ARB_STARVE_EN
  localparam int unsigned StW = $clog2(STARVE_LIM + 1);
  logic [StW-1:0] ch_lose_q, ch_lose_d, cca_lose_q, cca_lose_d;
  logic           ch_promo, cca_promo;

  assign ch_promo  = chReq && (ch_lose_q == StW'(STARVE_LIM));
  assign cca_promo = ccaReq && (cca_lose_q == StW'(STARVE_LIM));

  always_comb begin
    win_src = SrcNone;
    if (ch_promo)       win_src = SrcCh;
    else if (cca_promo) win_src = SrcCca;
    else if (ebReq)     win_src = SrcEb;
    else if (chReq)     win_src = SrcCh;
    else if (ccaReq)    win_src = SrcCca;
  end

  // Lose counters only move on IDLE-cycle arbitrations and saturate at the promotion limit.
  always_comb begin
    ch_lose_d  = ch_lose_q;
    cca_lose_d = cca_lose_q;
    if (state_q == StIdle) begin
      if (chReq) begin
        if (win_src == SrcCh)                    ch_lose_d = '0;
        else if (ch_lose_q != StW'(STARVE_LIM))  ch_lose_d = ch_lose_q + 1'b1;
      end
      if (ccaReq) begin
        if (win_src == SrcCca)                   cca_lose_d = '0;
        else if (cca_lose_q != StW'(STARVE_LIM)) cca_lose_d = cca_lose_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge FPGA_RESET) begin
    if (FPGA_RESET) begin
      ch_lose_q  <= '0;
      cca_lose_q <= '0;
    end else begin
      ch_lose_q  <= ch_lose_d;
      cca_lose_q <= cca_lose_d;
    end
  end
`else
  always_comb begin
    win_src = SrcNone;
    if (ebReq)       win_src = SrcEb;
    else if (chReq)  win_src = SrcCh;
    else if (ccaReq) win_src = SrcCca;
  end
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    adr_d   = adr_q;
    write_d = write_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    to_d    = to_q;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_src != SrcNone) begin
          state_d = StIssue;
          src_d   = win_src;
          case (win_src)
            SrcEb:   begin adr_d = ebAdr;  write_d = ebWrite; end
            SrcCh:   begin adr_d = chAdr;  write_d = chWrite; end
            default: begin adr_d = ccaAdr; write_d = 1'b0;    end
          endcase
        end
      end
      StIssue: begin
        if (memStart) begin
          to_d = '0;
          if (memResp) done = 1'b1;
          else         state_d = StWait;
        end
      end
      StWait: begin
        to_d = to_q + 1'b1;
        if (memResp) begin
          done = 1'b1;
        end else if (memRetry) begin
          if (retry_q < RtW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            gap_d   = '0;
            state_d = StRetry;
          end else begin
            state_d = StError;
          end
        end else if (to_q == ToW'(TIMEOUT_CYC - 1)) begin
          state_d = StError;
        end
      end
      StRetry: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapW'(RETRY_GAP - 1)) state_d = StIssue;
      end
      StError: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Completion releases ownership; the next arbitration happens in the following IDLE cycle.
    if (done) begin
      state_d = StIdle;
      src_d   = SrcNone;
      adr_d   = '0;
      write_d = 1'b0;
      retry_d = '0;
    end
  end

  always_ff @(posedge clk or posedge FPGA_RESET) begin
    if (FPGA_RESET) begin
      state_q <= StIdle;
      src_q   <= SrcNone;
      adr_q   <= '0;
      write_q <= 1'b0;
      retry_q <= '0;
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      adr_q   <= adr_d;
      write_q <= write_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  assign memReq   = (state_q == StIssue);
  assign memWrite = write_q;
  assign memAdr   = adr_q;
  assign memSrc   = src_q;
  assign ebDone   = done && (src_q == SrcEb);
  assign chDone   = done && (src_q == SrcCh);
  assign ccaDone  = done && (src_q == SrcCca);
  assign doneErr  = err;
  assign nxmErr   = err;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mbox_req_arb.sv
// Directed bench for mbox_req_arb: arbitration vector table plus retry, timeout, reset and
// starvation sequences.
module tb_mbox_req_arb;

  localparam int unsigned AW = 23;

  logic          clk = 1'b0;
  logic          FPGA_RESET;
  logic          ebReq, chReq, ccaReq, ebWrite, chWrite;
  logic [AW-1:0] ebAdr, chAdr, ccaAdr;
  logic          memReq, memWrite;
  logic [AW-1:0] memAdr;
  logic [1:0]    memSrc;
  logic          memStart, memResp, memRetry;
  logic          ebDone, chDone, ccaDone, doneErr, nxmErr, busy;

  always #5 clk = ~clk;

  mbox_req_arb #(
    .ADDR_W     (AW),
    .TIMEOUT_CYC(1024),
    .MAX_RETRY  (3),
    .RETRY_GAP  (4),
    .STARVE_LIM (8)
  ) dut (
    .clk       (clk),
    .FPGA_RESET(FPGA_RESET),
    .ebReq     (ebReq),
    .chReq     (chReq),
    .ccaReq    (ccaReq),
    .ebWrite   (ebWrite),
    .chWrite   (chWrite),
    .ebAdr     (ebAdr),
    .chAdr     (chAdr),
    .ccaAdr    (ccaAdr),
    .memReq    (memReq),
    .memWrite  (memWrite),
    .memAdr    (memAdr),
    .memSrc    (memSrc),
    .memStart  (memStart),
    .memResp   (memResp),
    .memRetry  (memRetry),
    .ebDone    (ebDone),
    .chDone    (chDone),
    .ccaDone   (ccaDone),
    .doneErr   (doneErr),
    .nxmErr    (nxmErr),
    .busy      (busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          eb, ch, cca, ebw, chw;
    logic [AW-1:0] eba, cha, ccaa;
    logic [1:0]    src;
    logic [AW-1:0] adr;
    logic          wr;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves time at posedge+1; all stimulus is driven from there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] dones();
    return {ebDone, chDone, ccaDone};
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Call right after cyc(); returns at posedge+3 of the first cycle with memReq high.
  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (memReq) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: memReq did not rise within 20 cycles", name);
    end
  endtask

  // Accepts and completes the next issued request in the same cycle.
  task automatic run_txn(input string name, output logic [1:0] src);
    bit ok;
    wait_req(name, ok);
    src      = memSrc;
    memStart = 1'b1;
    memResp  = 1'b1;
    #1;
    chk({name, " done"}, dones(), onehot(src));
    cyc();
    memStart = 1'b0;
    memResp  = 1'b0;
  endtask

  // Cycles from the first RETRY cycle until memReq reappears.
  task automatic count_gap(output int n);
    n = 1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (memReq) return;
      cyc();
      n++;
    end
  endtask

  task automatic retry_once(input string name);
    int n;
    memStart = 1'b1;
    cyc();
    memStart = 1'b0;
    memRetry = 1'b1;
    #2;
    chk({name, " no done on retry"}, dones(), 3'b000);
    cyc();
    memRetry = 1'b0;
    count_gap(n);
    chk({name, " gap"}, n, 5);
    chk({name, " adr"}, memAdr, 23'h2A5A5A);
    chk({name, " wr"}, memWrite, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] s, exp_s;
    bit         ok;
    int         n;

    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 23'h001234, 23'h000000, 23'h000000, 2'd1, 23'h001234, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 23'h000000, 23'h7FFFFF, 23'h000000, 2'd2, 23'h7FFFFF, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 23'h000000, 23'h000000, 23'h000001, 2'd3, 23'h000001, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 23'h0ABCDE, 23'h111111, 23'h000000, 2'd1, 23'h0ABCDE, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 23'h000000, 23'h3C3C3C, 23'h555555, 2'd2, 23'h3C3C3C, 1'b1};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 23'h400000, 23'h222222, 23'h333333, 2'd1, 23'h400000, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 23'h012345, 23'h000000, 23'h0F0F0F, 2'd1, 23'h012345, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 23'h000000, 23'h000FFF, 23'h000006, 2'd2, 23'h000FFF, 1'b0};

    FPGA_RESET = 1'b1;
    {ebReq, chReq, ccaReq, ebWrite, chWrite} = '0;
    ebAdr = '0; chAdr = '0; ccaAdr = '0;
    {memStart, memResp, memRetry} = '0;
    cyc();
    cyc();
    FPGA_RESET = 1'b0;
    #2;
    chk("rst memReq", memReq, 0);
    chk("rst memSrc", memSrc, 0);
    chk("rst memAdr", memAdr, 0);
    chk("rst memWrite", memWrite, 0);
    chk("rst dones", dones(), 0);
    chk("rst err", {doneErr, nxmErr}, 0);
    chk("rst busy", busy, 0);

    // Arbitration table: one-cycle grant, latched fields, immediate completion.
    for (int i = 0; i < 8; i++) begin
      cyc();
      ebReq = vt[i].eb; chReq = vt[i].ch; ccaReq = vt[i].cca;
      ebWrite = vt[i].ebw; chWrite = vt[i].chw;
      ebAdr = vt[i].eba; chAdr = vt[i].cha; ccaAdr = vt[i].ccaa;
      #2;
      chk($sformatf("vec%0d idle memReq", i), memReq, 0);
      cyc();
      #2;
      chk($sformatf("vec%0d memReq", i), memReq, 1);
      chk($sformatf("vec%0d memSrc", i), memSrc, vt[i].src);
      chk($sformatf("vec%0d memAdr", i), memAdr, vt[i].adr);
      chk($sformatf("vec%0d memWrite", i), memWrite, vt[i].wr);
      memStart = 1'b1;
      memResp  = 1'b1;
      #1;
      chk($sformatf("vec%0d done", i), dones(), onehot(vt[i].src));
      cyc();
      {memStart, memResp} = '0;
      {ebReq, chReq, ccaReq} = '0;
      #2;
      chk($sformatf("vec%0d busy after", i), busy, 0);
      chk($sformatf("vec%0d src after", i), memSrc, 0);
    end

    // Single EB read with memStart at +2 and memResp at +5.
    cyc();
    ebReq = 1'b1; ebWrite = 1'b0; ebAdr = 23'h001234;
    #2 chk("t1 c0 memReq", memReq, 0);
    cyc();
    #2 chk("t1 c1 memReq", memReq, 1);
    chk("t1 c1 memSrc", memSrc, 1);
    cyc();
    memStart = 1'b1;
    #2 chk("t1 c2 memReq", memReq, 1);
    cyc();
    memStart = 1'b0;
    #2 chk("t1 c3 memReq", memReq, 0);
    chk("t1 c3 busy", busy, 1);
    cyc();
    #2 chk("t1 c4 dones", dones(), 0);
    cyc();
    memResp = 1'b1;
    #2 chk("t1 c5 dones", dones(), 3'b100);
    chk("t1 c5 doneErr", doneErr, 0);
    cyc();
    memResp = 1'b0; ebReq = 1'b0;
    #2 chk("t1 c6 dones", dones(), 0);
    chk("t1 c6 busy", busy, 0);

    // All three at once: served EB, CH, CCA; owner drops after its Done.
    cyc();
    ebReq = 1'b1; chReq = 1'b1; ccaReq = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_txn($sformatf("t2 txn%0d", k), s);
      chk($sformatf("t2 order%0d", k), s, k + 1);
      case (s)
        2'd1:    ebReq = 1'b0;
        2'd2:    chReq = 1'b0;
        default: ccaReq = 1'b0;
      endcase
    end
    {ebReq, chReq, ccaReq} = '0;
    #2 chk("t2 idle after", busy, 0);

    // CH write: 3 retries then success.
    cyc();
    chReq = 1'b1; chWrite = 1'b1; chAdr = 23'h2A5A5A;
    cyc();
    #2 chk("t3 memReq", memReq, 1);
    for (int r = 0; r < 3; r++) retry_once($sformatf("t3a r%0d", r));
    memStart = 1'b1;
    cyc();
    memStart = 1'b0;
    memResp  = 1'b1;
    #2 chk("t3a done", dones(), 3'b010);
    chk("t3a err", {doneErr, nxmErr}, 0);
    cyc();
    memResp = 1'b0; chReq = 1'b0;
    #2 chk("t3a busy", busy, 0);

    // CH write: 4th retry is an error.
    cyc();
    chReq = 1'b1;
    cyc();
    #2 chk("t3b memReq", memReq, 1);
    for (int r = 0; r < 3; r++) retry_once($sformatf("t3b r%0d", r));
    memStart = 1'b1;
    cyc();
    memStart = 1'b0;
    memRetry = 1'b1;
    #2 chk("t3b 4th retry no done", dones(), 0);
    cyc();
    memRetry = 1'b0;
    #2 chk("t3b err done", dones(), 3'b010);
    chk("t3b err flags", {doneErr, nxmErr}, 2'b11);
    cyc();
    chReq = 1'b0;
    #2 chk("t3b nxm pulse", nxmErr, 0);
    chk("t3b busy", busy, 0);

    // EB read timeout.
    cyc();
    ebReq = 1'b1; ebWrite = 1'b0; ebAdr = 23'h00ABCD;
    cyc();
    #2 chk("t4 memReq", memReq, 1);
    memStart = 1'b1;
    cyc();
    memStart = 1'b0;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      #2;
      if (ebDone) break;
      cyc();
      n++;
    end
    chk("t4 timeout cycles", n, 1024);
    chk("t4 err flags", {doneErr, nxmErr}, 2'b11);
    cyc();
    ebReq = 1'b0;
    #2 chk("t4 after dones", dones(), 0);
    chk("t4 after nxm", nxmErr, 0);
    cyc();
    ebReq = 1'b1;
    run_txn("t4 next", s);
    chk("t4 next src", s, 1);
    ebReq = 1'b0;

    // Reset while in WAIT.
    cyc();
    ebReq = 1'b1; ebAdr = 23'h05A5A5; ebWrite = 1'b1;
    cyc();
    wait_req("t5 req", ok);
    memStart = 1'b1;
    cyc();
    memStart = 1'b0;
    #2 chk("t5 in wait", {busy, memReq}, 2'b10);
    #1 FPGA_RESET = 1'b1;
    #1;
    chk("t5 rst memReq", memReq, 0);
    chk("t5 rst memSrc", memSrc, 0);
    chk("t5 rst memAdr", memAdr, 0);
    chk("t5 rst memWrite", memWrite, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst dones", {dones(), doneErr, nxmErr}, 0);
    cyc();
    FPGA_RESET = 1'b0; ebReq = 1'b0; memResp = 1'b1;
    #2 chk("t5 stray resp", dones(), 0);
    chk("t5 idle", busy, 0);
    cyc();
    memResp = 1'b0;
    #2 chk("t5 still idle", busy, 0);
    cyc();
    ebReq = 1'b1;
    run_txn("t5 next", s);
    chk("t5 next src", s, 1);
    ebReq = 1'b0;

    // EB held continuously with CCA pending.
    cyc();
    ebReq = 1'b1; ccaReq = 1'b1; ccaAdr = 23'h000077;
    for (int k = 0; k < 12; k++) begin
`ifdef MBOX_ARB_STARVE_EN
      exp_s = (k == 8) ? 2'd3 : 2'd1;
`else
      exp_s = 2'd1;
`endif
      run_txn($sformatf("t6 arb%0d", k + 1), s);
      chk($sformatf("t6 arb%0d src", k + 1), s, exp_s);
    end
    {ebReq, ccaReq} = '0;
    cyc();
    #2 chk("t6 idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
